// File: rtl/ram_test_engine.sv
// rtl/ram_test_engine.sv - AXI4 master that fills RAM with an address pattern and checks one 4 KB page.
// One burst outstanding at a time; the word at byte address A is expected to hold A/4.
module ram_test_engine #(
   parameter int unsigned RAM_SIZE    = 65536,
   parameter int unsigned BURST_BEATS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_fill,
   input  logic        start_read,
   input  logic [31:0] read_addr,
   output logic        busy,
   output logic        done,
   output logic [31:0] error_count,
   output logic [31:0] first_error_addr,
   output logic [31:0] M_AXI_AWADDR,
   output logic [7:0]  M_AXI_AWLEN,
   output logic [2:0]  M_AXI_AWSIZE,
   output logic [1:0]  M_AXI_AWBURST,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WLAST,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic [7:0]  M_AXI_ARLEN,
   output logic [2:0]  M_AXI_ARSIZE,
   output logic [1:0]  M_AXI_ARBURST,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RLAST,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   localparam logic [31:0] BURST_BYTES = 32'(4 * BURST_BEATS);
   localparam logic [31:0] RAM_MASK    = 32'(RAM_SIZE - 1);
   localparam logic [31:0] FILL_LAST   = 32'(RAM_SIZE / (4 * BURST_BEATS) - 1);
   localparam logic [31:0] READ_LAST   = 32'(4096 / (4 * BURST_BEATS) - 1);
   localparam logic [7:0]  LAST_BEAT   = 8'(BURST_BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL_AW, S_FILL_W, S_FILL_B, S_READ_AR, S_READ_R, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] burst_addr;
   logic [31:0] burst_idx;
   logic [7:0]  beat;
   logic        err_seen;
   logic [31:0] beat_addr;
   logic [31:0] expected_word;
   logic [31:0] next_burst_addr;
   logic        last_beat;
   logic        bad_beat;
   logic        unused_ok;

   assign beat_addr       = burst_addr + {22'd0, beat, 2'b00};
   assign expected_word   = {2'b00, beat_addr[31:2]};
   assign next_burst_addr = (burst_addr + BURST_BYTES) & RAM_MASK;
   assign last_beat       = (beat == LAST_BEAT);
   assign bad_beat        = (M_AXI_RDATA != expected_word) || (M_AXI_RRESP != 2'b00);
   // Burst end comes from the beat counter, so RLAST is deliberately not consulted.
   assign unused_ok       = ^{M_AXI_RLAST, read_addr[11:0], beat_addr[1:0]};

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Payload outputs are driven only while their VALID is up, so they read zero otherwise.
   always_comb begin
      state_nxt     = state;
      busy          = 1'b1;
      done          = 1'b0;
      M_AXI_AWADDR  = 32'd0;
      M_AXI_AWLEN   = 8'd0;
      M_AXI_AWSIZE  = 3'd0;
      M_AXI_AWBURST = 2'd0;
      M_AXI_AWVALID = 1'b0;
      M_AXI_WDATA   = 32'd0;
      M_AXI_WSTRB   = 4'd0;
      M_AXI_WLAST   = 1'b0;
      M_AXI_WVALID  = 1'b0;
      M_AXI_BREADY  = 1'b0;
      M_AXI_ARADDR  = 32'd0;
      M_AXI_ARLEN   = 8'd0;
      M_AXI_ARSIZE  = 3'd0;
      M_AXI_ARBURST = 2'd0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start_fill)      state_nxt = S_FILL_AW;
            else if (start_read) state_nxt = S_READ_AR;
         end
         S_FILL_AW: begin
            M_AXI_AWVALID = 1'b1;
            M_AXI_AWADDR  = burst_addr;
            M_AXI_AWLEN   = LAST_BEAT;
            M_AXI_AWSIZE  = 3'd2;
            M_AXI_AWBURST = 2'b01;
            if (M_AXI_AWREADY) state_nxt = S_FILL_W;
         end
         S_FILL_W: begin
            M_AXI_WVALID = 1'b1;
            M_AXI_WDATA  = expected_word;
            M_AXI_WSTRB  = 4'hF;
            M_AXI_WLAST  = last_beat;
            if (M_AXI_WREADY && last_beat) state_nxt = S_FILL_B;
         end
         S_FILL_B: begin
            M_AXI_BREADY = 1'b1;
            if (M_AXI_BVALID) state_nxt = (burst_idx == FILL_LAST) ? S_DONE : S_FILL_AW;
         end
         S_READ_AR: begin
            M_AXI_ARVALID = 1'b1;
            M_AXI_ARADDR  = burst_addr;
            M_AXI_ARLEN   = LAST_BEAT;
            M_AXI_ARSIZE  = 3'd2;
            M_AXI_ARBURST = 2'b01;
            if (M_AXI_ARREADY) state_nxt = S_READ_R;
         end
         S_READ_R: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID && last_beat)
               state_nxt = (burst_idx == READ_LAST) ? S_DONE : S_READ_AR;
         end
         S_DONE: begin
            busy      = 1'b0;
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         burst_addr       <= 32'd0;
         burst_idx        <= 32'd0;
         beat             <= 8'd0;
         err_seen         <= 1'b0;
         error_count      <= 32'd0;
         first_error_addr <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               beat      <= 8'd0;
               burst_idx <= 32'd0;
               if (start_fill || start_read) begin
                  error_count      <= 32'd0;
                  first_error_addr <= 32'd0;
                  err_seen         <= 1'b0;
                  burst_addr       <= start_fill ? 32'd0 : ({read_addr[31:12], 12'h000} & RAM_MASK);
               end
            end
            S_FILL_W: begin
               if (M_AXI_WREADY) beat <= last_beat ? 8'd0 : beat + 8'd1;
            end
            S_FILL_B: begin
               if (M_AXI_BVALID) begin
                  if (M_AXI_BRESP != 2'b00) error_count <= sat_inc(error_count);
                  burst_addr <= next_burst_addr;
                  burst_idx  <= burst_idx + 32'd1;
               end
            end
            S_READ_R: begin
               if (M_AXI_RVALID) begin
                  beat <= last_beat ? 8'd0 : beat + 8'd1;
                  if (bad_beat) begin
                     error_count <= sat_inc(error_count);
                     if (!err_seen) begin
                        first_error_addr <= beat_addr;
                        err_seen         <= 1'b1;
                     end
                  end
                  if (last_beat) begin
                     burst_addr <= next_burst_addr;
                     burst_idx  <= burst_idx + 32'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
